// File: rtl/input_stream_reader.sv
// Per-stream host read engine: splits buffer descriptors into read requests,
// tracks completions and forwards returned host data with a job-final tlast.
module input_stream_reader #(
    parameter int unsigned AXI_STRM_ID           = 0,
    parameter int unsigned TRANSFER_LENGTH_BYTES = 4096,
    parameter int unsigned MAX_OUTSTANDING       = 4,
    parameter int unsigned VADDR_BITS            = 48,
    parameter int unsigned LEN_BITS              = 28
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  buf_valid,
    output logic                  buf_ready,
    input  logic [VADDR_BITS-1:0] buf_vaddr,
    input  logic [LEN_BITS-1:0]   buf_len,
    input  logic                  buf_last,
    output logic                  sq_rd_valid,
    input  logic                  sq_rd_ready,
    output logic [VADDR_BITS-1:0] sq_rd_vaddr,
    output logic [LEN_BITS-1:0]   sq_rd_len,
    output logic [1:0]            sq_rd_strm,
    output logic                  sq_rd_last,
    input  logic                  cq_rd_valid,
    output logic                  cq_rd_ready,
    input  logic                  host_tvalid,
    output logic                  host_tready,
    input  logic [511:0]          host_tdata,
    input  logic [63:0]           host_tkeep,
    input  logic                  host_tlast,
    output logic                  data_out_tvalid,
    input  logic                  data_out_tready,
    output logic [511:0]          data_out_tdata,
    output logic [63:0]           data_out_tkeep,
    output logic                  data_out_tlast,
    output logic                  reading_done,
    output logic                  err_unexpected
);
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [LEN_BITS-1:0] XFER_LEN = LEN_BITS'(TRANSFER_LENGTH_BYTES);
    localparam logic [OUT_W-1:0]    MAX_OUT  = OUT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                state;
    logic [VADDR_BITS-1:0] vaddr;
    logic [LEN_BITS-1:0]   remaining;
    logic                  last_buf;
    logic [OUT_W-1:0]      outstanding;
    logic [31:0]           beats_pending;

    logic                  skid_valid;
    logic [511:0]          skid_tdata;
    logic [63:0]           skid_tkeep;
    logic                  skid_tlast;

    logic                  buf_hs, sq_hs, cq_hs, out_hs, host_hs;
    logic                  store, beat_final, out_free;
    logic [1:0]            skid_count, occ_next;
    logic [31:0]           unreceived;
    logic [LEN_BITS-1:0]   req_len;
    logic                  unused_ok;

    assign buf_hs     = buf_valid && buf_ready;
    assign sq_hs      = sq_rd_valid && sq_rd_ready;
    assign cq_hs      = cq_rd_valid && cq_rd_ready;
    assign out_hs     = data_out_tvalid && data_out_tready;
    assign host_hs    = host_tvalid && host_tready;
    assign out_free   = !data_out_tvalid || out_hs;
    assign sq_rd_strm = 2'(AXI_STRM_ID);
    assign req_len    = (remaining > XFER_LEN) ? XFER_LEN : remaining;
    assign unused_ok  = ^{host_tlast, buf_len[5:0]};

    // Beats still owed by the host: pending beats minus those already buffered.
    assign skid_count = 2'(data_out_tvalid) + 2'(skid_valid);
    assign unreceived = beats_pending - 32'(skid_count);
    assign store      = host_hs && (unreceived != 32'd0);
    assign occ_next   = skid_count + 2'(store) - 2'(out_hs);
    assign beat_final = last_buf && (remaining == '0) && (state == DRAIN)
                        && (unreceived == 32'd1);

    // Descriptor intake and request issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            buf_ready    <= 1'b0;
            vaddr        <= '0;
            remaining    <= '0;
            last_buf     <= 1'b0;
            sq_rd_valid  <= 1'b0;
            sq_rd_vaddr  <= '0;
            sq_rd_len    <= '0;
            sq_rd_last   <= 1'b0;
            reading_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    buf_ready <= 1'b1;
                    if (buf_hs) begin
                        buf_ready <= 1'b0;
                        vaddr     <= buf_vaddr;
                        remaining <= {buf_len[LEN_BITS-1:6], 6'b0};
                        last_buf  <= buf_last;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (sq_rd_valid) begin
                        if (sq_rd_ready) begin
                            sq_rd_valid <= 1'b0;
                            vaddr       <= vaddr + VADDR_BITS'(sq_rd_len);
                            remaining   <= remaining - sq_rd_len;
                            if (sq_rd_last) state <= last_buf ? DRAIN : IDLE;
                        end
                    end else if (remaining == '0) begin
                        state <= last_buf ? DRAIN : IDLE;
                    end else if (outstanding < MAX_OUT) begin
                        sq_rd_valid <= 1'b1;
                        sq_rd_vaddr <= vaddr;
                        sq_rd_len   <= req_len;
                        sq_rd_last  <= (req_len == remaining);
                    end
                end
                DRAIN: begin
                    if (outstanding == '0 && beats_pending == 32'd0
                        && !skid_valid && !data_out_tvalid) begin
                        state        <= DONE;
                        reading_done <= 1'b1;
                    end
                end
                DONE:    reading_done <= 1'b1;
                default: state <= IDLE;
            endcase
        end
    end

    // Outstanding-request and pending-beat accounting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding   <= '0;
            beats_pending <= 32'd0;
        end else begin
            if (sq_hs && !cq_hs)
                outstanding <= outstanding + OUT_W'(1);
            else if (!sq_hs && cq_hs && outstanding != '0)
                outstanding <= outstanding - OUT_W'(1);
            beats_pending <= beats_pending
                             + (sq_hs ? 32'(sq_rd_len[LEN_BITS-1:6]) : 32'd0)
                             - 32'(out_hs);
        end
    end

    // Two-entry skid buffer; data_out_* is the head entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cq_rd_ready     <= 1'b0;
            host_tready     <= 1'b0;
            err_unexpected  <= 1'b0;
            data_out_tvalid <= 1'b0;
            data_out_tdata  <= '0;
            data_out_tkeep  <= '0;
            data_out_tlast  <= 1'b0;
            skid_valid      <= 1'b0;
            skid_tdata      <= '0;
            skid_tkeep      <= '0;
            skid_tlast      <= 1'b0;
        end else begin
            cq_rd_ready <= 1'b1;
            host_tready <= (occ_next < 2'd2);
            if (host_hs && !store) err_unexpected <= 1'b1;
            if (out_free) begin
                if (skid_valid) begin
                    data_out_tvalid <= 1'b1;
                    data_out_tdata  <= skid_tdata;
                    data_out_tkeep  <= skid_tkeep;
                    data_out_tlast  <= skid_tlast;
                    skid_valid      <= store;
                    if (store) begin
                        skid_tdata <= host_tdata;
                        skid_tkeep <= host_tkeep;
                        skid_tlast <= beat_final;
                    end
                end else begin
                    data_out_tvalid <= store;
                    data_out_tlast  <= store && beat_final;
                    if (store) begin
                        data_out_tdata <= host_tdata;
                        data_out_tkeep <= host_tkeep;
                    end
                end
            end else if (store) begin
                skid_valid <= 1'b1;
                skid_tdata <= host_tdata;
                skid_tkeep <= host_tkeep;
                skid_tlast <= beat_final;
            end
        end
    end
endmodule

// File: tb/tb_input_stream_reader.sv
// Directed bench for input_stream_reader: table of single-buffer jobs plus
// hand-written sequences for outstanding limits, zero-length and reset.
module tb_input_stream_reader;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         buf_valid, buf_ready, buf_last;
    logic [47:0]  buf_vaddr;
    logic [27:0]  buf_len;
    logic         sq_rd_valid, sq_rd_ready, sq_rd_last;
    logic [47:0]  sq_rd_vaddr;
    logic [27:0]  sq_rd_len;
    logic [1:0]   sq_rd_strm;
    logic         cq_rd_valid, cq_rd_ready;
    logic         host_tvalid, host_tready, host_tlast;
    logic [511:0] host_tdata;
    logic [63:0]  host_tkeep;
    logic         data_out_tvalid, data_out_tready, data_out_tlast;
    logic [511:0] data_out_tdata;
    logic [63:0]  data_out_tkeep;
    logic         reading_done, err_unexpected;

    input_stream_reader #(
        .AXI_STRM_ID(1), .TRANSFER_LENGTH_BYTES(4096), .MAX_OUTSTANDING(4),
        .VADDR_BITS(48), .LEN_BITS(28)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .buf_valid(buf_valid), .buf_ready(buf_ready), .buf_vaddr(buf_vaddr),
        .buf_len(buf_len), .buf_last(buf_last),
        .sq_rd_valid(sq_rd_valid), .sq_rd_ready(sq_rd_ready), .sq_rd_vaddr(sq_rd_vaddr),
        .sq_rd_len(sq_rd_len), .sq_rd_strm(sq_rd_strm), .sq_rd_last(sq_rd_last),
        .cq_rd_valid(cq_rd_valid), .cq_rd_ready(cq_rd_ready),
        .host_tvalid(host_tvalid), .host_tready(host_tready), .host_tdata(host_tdata),
        .host_tkeep(host_tkeep), .host_tlast(host_tlast),
        .data_out_tvalid(data_out_tvalid), .data_out_tready(data_out_tready),
        .data_out_tdata(data_out_tdata), .data_out_tkeep(data_out_tkeep),
        .data_out_tlast(data_out_tlast),
        .reading_done(reading_done), .err_unexpected(err_unexpected)
    );

    always #5 clk = ~clk;

    typedef struct { logic [47:0] vaddr; logic [27:0] len; logic last; } req_t;
    typedef struct {
        logic [47:0] vaddr; logic [27:0] len;
        int nreq; logic [27:0] last_len; int beats; int rnd;
    } vec_t;

    int checks = 0, errors = 0;
    req_t req_log[$];
    req_t buf_q[$];
    logic [27:0] cq_q[$];
    int beat_q[$];
    int next_host_beat, next_out_beat, job_beats;
    int tlast_cnt, tlast_beat, order_err, rd_early, strm_bad, stab_err;
    int sq_mode, out_mode, cq_hold, cq_force;
    logic stall_prev;
    req_t stall_req;
    vec_t vecs[7];

    function automatic logic [511:0] data_of(input int k);
        logic [31:0] w;
        w = 32'(k) ^ 32'hA5A5_0000;
        return {16{w}};
    endfunction

    function automatic logic [63:0] keep_of(input int k);
        logic [31:0] w;
        w = 32'(k) * 32'h0101_0101;
        return {~w, w};
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One bench cycle: drive all inputs at negedge; handshakes complete at next posedge.
    task automatic step();
        int nb;
        @(negedge clk);
        if (stall_prev && (!sq_rd_valid || sq_rd_vaddr !== stall_req.vaddr
                           || sq_rd_len !== stall_req.len || sq_rd_last !== stall_req.last))
            stab_err++;
        if (buf_q.size() > 0) begin
            buf_valid = 1'b1;
            buf_vaddr = buf_q[0].vaddr;
            buf_len   = buf_q[0].len;
            buf_last  = buf_q[0].last;
            if (buf_ready) void'(buf_q.pop_front());
        end else begin
            buf_valid = 1'b0;
        end
        cq_rd_valid = 1'b0;
        if (cq_q.size() > 0 && (cq_force != 0 || (cq_hold == 0 && $urandom_range(0, 3) != 0))) begin
            cq_rd_valid = 1'b1;
            cq_force = 0;
            if (cq_rd_ready) begin
                nb = int'(cq_q.pop_front() >> 6);
                for (int b = 0; b < nb; b++) begin
                    beat_q.push_back(next_host_beat);
                    next_host_beat++;
                end
            end
        end
        case (sq_mode)
            0:       sq_rd_ready = 1'b1;
            1:       sq_rd_ready = 1'($urandom_range(0, 1));
            default: sq_rd_ready = 1'b0;
        endcase
        stall_prev = sq_rd_valid && !sq_rd_ready;
        stall_req  = '{sq_rd_vaddr, sq_rd_len, sq_rd_last};
        if (sq_rd_valid && sq_rd_ready) begin
            req_log.push_back('{sq_rd_vaddr, sq_rd_len, sq_rd_last});
            cq_q.push_back(sq_rd_len);
            if (sq_rd_strm !== 2'd1) strm_bad++;
        end
        if (beat_q.size() > 0) begin
            host_tvalid = 1'b1;
            host_tdata  = data_of(beat_q[0]);
            host_tkeep  = keep_of(beat_q[0]);
            host_tlast  = 1'b0;
            if (host_tready) void'(beat_q.pop_front());
        end else begin
            host_tvalid = 1'b0;
        end
        data_out_tready = (out_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (data_out_tvalid && data_out_tready) begin
            if (data_out_tdata !== data_of(next_out_beat) || data_out_tkeep !== keep_of(next_out_beat))
                order_err++;
            next_out_beat++;
            if (data_out_tlast) begin
                tlast_cnt++;
                tlast_beat = next_out_beat;
            end
        end
        if (reading_done && next_out_beat < job_beats) rd_early++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        buf_valid = 1'b0; sq_rd_ready = 1'b0; cq_rd_valid = 1'b0;
        host_tvalid = 1'b0; data_out_tready = 1'b0;
        buf_q.delete(); req_log.delete(); cq_q.delete(); beat_q.delete();
        next_host_beat = 0; next_out_beat = 0; tlast_cnt = 0; tlast_beat = -1;
        order_err = 0; rd_early = 0; strm_bad = 0; stab_err = 0;
        stall_prev = 1'b0; cq_force = 0; cq_hold = 0; sq_mode = 0; out_mode = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_until_done(input int budget);
        int n;
        n = 0;
        while (!reading_done && n < budget) begin
            step();
            n++;
        end
        repeat (4) step();
    endtask

    task automatic check_job(input string name, input logic [47:0] va, input int nreq,
                             input logic [27:0] last_len, input int beats);
        int bad;
        bad = 0;
        check({name, ".nreq"}, req_log.size(), nreq);
        for (int k = 0; k < req_log.size() && k < nreq; k++) begin
            if (req_log[k].vaddr !== va + 48'(k) * 48'd4096) bad++;
            if (req_log[k].len !== ((k == nreq - 1) ? last_len : 28'd4096)) bad++;
            if (req_log[k].last !== 1'(k == nreq - 1)) bad++;
        end
        check({name, ".req_fields"}, bad, 0);
        check({name, ".beats"}, next_out_beat, beats);
        check({name, ".order"}, order_err, 0);
        check({name, ".tlast_cnt"}, tlast_cnt, (beats > 0) ? 1 : 0);
        if (beats > 0) check({name, ".tlast_pos"}, tlast_beat, beats);
        check({name, ".done"}, reading_done, 1);
        check({name, ".done_early"}, rd_early, 0);
        check({name, ".strm"}, strm_bad, 0);
        check({name, ".req_stable"}, stab_err, 0);
        check({name, ".err"}, err_unexpected, 0);
    endtask

    task automatic check_req(input string name, input int k, input logic [47:0] va,
                             input logic [27:0] len, input logic last);
        if (req_log.size() > k) begin
            check({name, ".vaddr"}, req_log[k].vaddr, va);
            check({name, ".len"}, req_log[k].len, len);
            check({name, ".last"}, req_log[k].last, last);
        end else begin
            check({name, ".missing"}, req_log.size(), k + 1);
        end
    endtask

    initial begin
        int n;
        vecs[0] = '{48'h1000,   28'd8192,  2, 28'd4096, 128, 0};
        vecs[1] = '{48'h0,      28'd10000, 3, 28'd1792, 156, 1};
        vecs[2] = '{48'h40,     28'd64,    1, 28'd64,   1,   0};
        vecs[3] = '{48'hABC000, 28'd4096,  1, 28'd4096, 64,  1};
        vecs[4] = '{48'h2000,   28'd4159,  1, 28'd4096, 64,  0};
        vecs[5] = '{48'h100,    28'd4160,  2, 28'd64,   65,  1};
        vecs[6] = '{48'h8000,   28'd0,     0, 28'd0,    0,   0};

        rst_n = 1'b1;
        buf_valid = 0; buf_vaddr = '0; buf_len = '0; buf_last = 0;
        sq_rd_ready = 0; cq_rd_valid = 0; host_tvalid = 0; host_tdata = '0;
        host_tkeep = '0; host_tlast = 0; data_out_tready = 0;
        #2 rst_n = 1'b0;
        #1;
        check("reset.outputs", {buf_ready, sq_rd_valid, cq_rd_ready, host_tready,
                                data_out_tvalid, data_out_tlast, reading_done, err_unexpected}, 0);
        do_reset();
        @(negedge clk); @(negedge clk);
        check("post_reset.buf_ready", buf_ready, 1);
        check("post_reset.cq_ready", cq_rd_ready, 1);
        check("post_reset.host_ready", host_tready, 1);
        check("post_reset.done", reading_done, 0);

        // Single-buffer jobs from the table
        for (int i = 0; i < 7; i++) begin
            do_reset();
            sq_mode = vecs[i].rnd; out_mode = vecs[i].rnd;
            job_beats = vecs[i].beats;
            buf_q.push_back('{vecs[i].vaddr, vecs[i].len, 1'b1});
            run_until_done(3000);
            check_job($sformatf("vec%0d", i), vecs[i].vaddr, vecs[i].nreq,
                      vecs[i].last_len, vecs[i].beats);
        end

        // Outstanding limit with withheld completions
        do_reset();
        cq_hold = 1; job_beats = 512;
        buf_q.push_back('{48'h40000, 28'd32768, 1'b1});
        repeat (30) step();
        check("os.issued4", req_log.size(), 4);
        check("os.valid_low", sq_rd_valid, 0);
        sq_mode = 2; cq_force = 1;
        repeat (5) step();
        check("os.fifth_valid", sq_rd_valid, 1);
        check("os.still4", req_log.size(), 4);
        sq_mode = 0; cq_force = 1;
        step();
        check("os.sim_hs", req_log.size(), 5);
        repeat (10) step();
        check("os.sixth_only", req_log.size(), 6);
        cq_hold = 0;
        run_until_done(3000);
        check_job("os", 48'h40000, 8, 28'd4096, 512);

        // Mixed buffers including a zero-length one, random backpressure
        do_reset();
        sq_mode = 1; out_mode = 1; job_beats = 48;
        buf_q.push_back('{48'h10000, 28'd1024, 1'b0});
        buf_q.push_back('{48'h30000, 28'd0,    1'b0});
        buf_q.push_back('{48'h20000, 28'd2048, 1'b1});
        run_until_done(3000);
        check("mix.nreq", req_log.size(), 2);
        check_req("mix.r0", 0, 48'h10000, 28'd1024, 1'b1);
        check_req("mix.r1", 1, 48'h20000, 28'd2048, 1'b1);
        check("mix.beats", next_out_beat, 48);
        check("mix.order", order_err, 0);
        check("mix.tlast_cnt", tlast_cnt, 1);
        check("mix.tlast_pos", tlast_beat, 48);
        check("mix.done", reading_done, 1);
        check("mix.done_early", rd_early, 0);

        // Zero-length final buffer: done within 3 cycles of acceptance
        do_reset();
        job_beats = 0;
        buf_q.push_back('{48'h0, 28'd0, 1'b1});
        n = 0;
        while (buf_q.size() > 0 && n < 20) begin step(); n++; end
        n = 0;
        while (!reading_done && n < 10) begin step(); n++; end
        check("zl.latency_le3", int'(n <= 3), 1);
        check("zl.nreq", req_log.size(), 0);
        check("zl.beats", next_out_beat, 0);
        check("zl.tlast", tlast_cnt, 0);

        // Reset mid-transfer, then a fresh job and an unexpected host beat
        do_reset();
        job_beats = 128;
        buf_q.push_back('{48'h1000, 28'd8192, 1'b1});
        repeat (40) step();
        #2 rst_n = 1'b0;
        #1;
        check("midrst.outputs", {buf_ready, sq_rd_valid, cq_rd_ready, host_tready,
                                 data_out_tvalid, data_out_tlast, reading_done, err_unexpected}, 0);
        do_reset();
        job_beats = 0;
        repeat (8) step();
        check("midrst.no_beats", next_out_beat, 0);
        check("midrst.no_reqs", req_log.size(), 0);
        job_beats = 64;
        buf_q.push_back('{48'h5000, 28'd4096, 1'b1});
        run_until_done(3000);
        check_job("after_rst", 48'h5000, 1, 28'd4096, 64);
        beat_q.push_back(next_host_beat);
        repeat (5) step();
        check("unexpected.err", err_unexpected, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
